// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory port arbiter: size codes, owner
// encoding, pipeline stage records and the alignment helper.
package dmem_pkg;

  localparam logic [1:0]  SIZE_WORD = 2'b00;
  localparam logic [1:0]  SIZE_HALF = 2'b01;
  localparam logic [1:0]  SIZE_BYTE = 2'b10;

  localparam logic [31:0] DATA_BASE_DEFAULT = 32'h1001_0000;

  typedef enum logic {
    OWN_M0 = 1'b0,
    OWN_M1 = 1'b1
  } owner_e;

  // Request held in the ACCESS stage; addr is already translated.
  typedef struct packed {
    logic        valid;
    owner_e      owner;
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        mis;
  } access_t;

  // Result held in the RESP stage.
  typedef struct packed {
    logic        valid;
    owner_e      owner;
    logic        err;
    logic [31:0] rdata;
  } resp_t;

  // The reserved code 2'b11 behaves as a word access.
  function automatic logic [1:0] norm_size(input logic [1:0] size);
    return (size == 2'b11) ? SIZE_WORD : size;
  endfunction

  // Words need addr[1:0]==0, halves need addr[0]==0, bytes are always fine.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    logic mis;
    mis = 1'b0;
    if (size == SIZE_WORD)      mis = (lo != 2'b00);
    else if (size == SIZE_HALF) mis = lo[0];
    return mis;
  endfunction

endpackage

// File: rtl/starve_counter.sv
// Counts consecutive cycles the low-priority requester waits; saturates at
// LIMIT and flags when that limit is reached so the arbiter can override.
module starve_counter #(
  parameter int LIMIT = 4
) (
  input  logic clk_in,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  localparam logic [3:0] LIM = 4'(LIMIT);

  logic [3:0] r_cnt;

  // Clear has priority; increment stops once the limit is held.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      r_cnt <= 4'd0;
    end else if (clr) begin
      r_cnt <= 4'd0;
    end else if (inc && (r_cnt != LIM)) begin
      r_cnt <= r_cnt + 4'd1;
    end
  end

  assign at_limit = (r_cnt == LIM);

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares one DMEM port between the CPU (M0) and the debug/loader port (M1).
// Accepts at most one request per cycle, translates the MARS address,
// blocks misaligned accesses, and returns a one-cycle response pulse two
// cycles after acceptance.
//
// Handshake: a request is taken at the rising edge where mX_req & mX_gnt;
// the requester holds req and payload stable until then. Responses have no
// backpressure: mX_rvalid is a single-cycle pulse that must be consumed.
module dmem_port_arbiter
  import dmem_pkg::*;
#(
  parameter logic [31:0] DATA_BASE    = DATA_BASE_DEFAULT,
  parameter int          STARVE_LIMIT = 4
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [1:0]  m0_size,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [1:0]  m1_size,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic        dm_ena,
  output logic        dm_wena,
  output logic [1:0]  dm_size,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata
);

  access_t     r_acc;
  resp_t       r_resp;

  logic        w_starved;
  logic        w_m1_win;
  logic        w_accept;
  owner_e      w_owner;
  logic        w_we;
  logic [1:0]  w_size;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;

  starve_counter #(
    .LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk_in   (clk_in),
    .reset    (reset),
    .inc      (m1_req & ~m1_gnt),
    .clr      (~m1_req | m1_gnt),
    .at_limit (w_starved)
  );

  // M1 wins when alone or starved; grants are forced low while in reset.
  assign w_m1_win = m1_req & (~m0_req | w_starved);
  assign m1_gnt   = reset & w_m1_win;
  assign m0_gnt   = reset & m0_req & ~w_m1_win;
  assign w_accept = m0_gnt | m1_gnt;

  assign w_owner  = m1_gnt ? OWN_M1 : OWN_M0;
  assign w_we     = m1_gnt ? m1_we    : m0_we;
  assign w_size   = norm_size(m1_gnt ? m1_size : m0_size);
  assign w_addr   = m1_gnt ? m1_addr  : m0_addr;
  assign w_wdata  = m1_gnt ? m1_wdata : m0_wdata;

  // ACCESS stage: capture the granted request with its translated address.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      r_acc <= '0;
    end else begin
      r_acc.valid <= w_accept;
      if (w_accept) begin
        r_acc.owner <= w_owner;
        r_acc.we    <= w_we;
        r_acc.size  <= w_size;
        r_acc.addr  <= w_addr - DATA_BASE;
        r_acc.wdata <= w_wdata;
        r_acc.mis   <= is_misaligned(w_size, w_addr[1:0]);
      end
    end
  end

  assign dm_ena   = r_acc.valid & ~r_acc.mis;
  assign dm_wena  = dm_ena & r_acc.we;
  assign dm_size  = r_acc.size;
  assign dm_addr  = r_acc.addr;
  assign dm_wdata = r_acc.wdata;

  // RESP stage: latch read data (zero for writes and errors) and the owner.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      r_resp <= '0;
    end else begin
      r_resp.valid <= r_acc.valid;
      r_resp.owner <= r_acc.owner;
      r_resp.err   <= r_acc.valid & r_acc.mis;
      r_resp.rdata <= (r_acc.valid & ~r_acc.mis & ~r_acc.we) ? dm_rdata : 32'h0;
    end
  end

  assign m0_rvalid = r_resp.valid & (r_resp.owner == OWN_M0);
  assign m1_rvalid = r_resp.valid & (r_resp.owner == OWN_M1);
  assign m0_rdata  = m0_rvalid ? r_resp.rdata : 32'h0;
  assign m1_rdata  = m1_rvalid ? r_resp.rdata : 32'h0;
  assign m0_err    = m0_rvalid & r_resp.err;
  assign m1_err    = m1_rvalid & r_resp.err;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter: per-cycle vector table plus
// hand-written starvation and mid-transaction reset sequences, with a
// small behavioural DMEM attached to the memory side.
module tb_dmem_port_arbiter;

  localparam logic [1:0] SW = 2'b00;
  localparam logic [1:0] SH = 2'b01;
  localparam logic [1:0] SB = 2'b10;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  typedef struct packed {
    logic        rv;
    logic        err;
    logic [31:0] rd;
  } rsp_t;

  typedef struct packed {
    logic        ena;
    logic        wena;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dm_t;

  typedef struct packed {
    req_t       m0;
    req_t       m1;
    logic [1:0] gnt;   // {m1_gnt, m0_gnt}
    rsp_t       r0;
    rsp_t       r1;
    dm_t        dm;
  } vec_t;

  localparam req_t IDLE = '0;
  localparam rsp_t NR   = '0;
  localparam dm_t  DOFF = '0;
  localparam int   NVEC = 22;

  // clock / reset
  logic clk_in = 1'b0;
  logic reset  = 1'b0;
  always #5 clk_in = ~clk_in;

  logic        m0_req, m0_we, m1_req, m1_we;
  logic [1:0]  m0_size, m1_size;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        dm_ena, dm_wena;
  logic [1:0]  dm_size;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;

  dmem_port_arbiter #(
    .DATA_BASE    (32'h1001_0000),
    .STARVE_LIMIT (4)
  ) dut (
    .clk_in    (clk_in),
    .reset     (reset),
    .m0_req    (m0_req),
    .m0_we     (m0_we),
    .m0_size   (m0_size),
    .m0_addr   (m0_addr),
    .m0_wdata  (m0_wdata),
    .m0_gnt    (m0_gnt),
    .m0_rvalid (m0_rvalid),
    .m0_rdata  (m0_rdata),
    .m0_err    (m0_err),
    .m1_req    (m1_req),
    .m1_we     (m1_we),
    .m1_size   (m1_size),
    .m1_addr   (m1_addr),
    .m1_wdata  (m1_wdata),
    .m1_gnt    (m1_gnt),
    .m1_rvalid (m1_rvalid),
    .m1_rdata  (m1_rdata),
    .m1_err    (m1_err),
    .dm_ena    (dm_ena),
    .dm_wena   (dm_wena),
    .dm_size   (dm_size),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_rdata  (dm_rdata)
  );

  // Behavioural DMEM: 16 words, little-endian lanes, combinational read,
  // write at the clock edge, preloaded while reset is low.
  logic [31:0] mem [16];

  function automatic logic [31:0] mem_merge(input logic [31:0] old, input logic [31:0] wd,
                                            input logic [1:0] lo, input logic [1:0] sz);
    logic [31:0] r;
    r = old;
    if (sz == SB)      r[{lo, 3'b000} +: 8]     = wd[7:0];
    else if (sz == SH) r[{lo[1], 4'b0000} +: 16] = wd[15:0];
    else               r = wd;
    return r;
  endfunction

  function automatic logic [31:0] mem_read(input logic [31:0] w, input logic [1:0] lo,
                                           input logic [1:0] sz);
    if (sz == SB) return {24'h0, w[{lo, 3'b000} +: 8]};
    if (sz == SH) return {16'h0, w[{lo[1], 4'b0000} +: 16]};
    return w;
  endfunction

  always @(posedge clk_in) begin
    if (!reset) begin
      for (int k = 0; k < 16; k++) mem[k] <= 32'h0;
      mem[0] <= 32'h1122_3344;
      mem[1] <= 32'hDEAD_BEEF;
    end else if (dm_ena && dm_wena) begin
      mem[dm_addr[5:2]] <= mem_merge(mem[dm_addr[5:2]], dm_wdata, dm_addr[1:0], dm_size);
    end
  end

  assign dm_rdata = mem_read(mem[dm_addr[5:2]], dm_addr[1:0], dm_size);

  // scoreboard counters and compare helper
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks
  function automatic req_t rd(input logic [1:0] s, input logic [31:0] a);
    return '{req: 1'b1, we: 1'b0, size: s, addr: a, wdata: 32'h0};
  endfunction

  function automatic req_t wr(input logic [1:0] s, input logic [31:0] a, input logic [31:0] d);
    return '{req: 1'b1, we: 1'b1, size: s, addr: a, wdata: d};
  endfunction

  function automatic rsp_t rsp(input logic [31:0] d, input logic e);
    return '{rv: 1'b1, err: e, rd: d};
  endfunction

  function automatic dm_t dmx(input logic w, input logic [1:0] s, input logic [31:0] a,
                              input logic [31:0] d);
    return '{ena: 1'b1, wena: w, size: s, addr: a, wdata: d};
  endfunction

  task automatic drive(input req_t a, input req_t b);
    m0_req = a.req; m0_we = a.we; m0_size = a.size; m0_addr = a.addr; m0_wdata = a.wdata;
    m1_req = b.req; m1_we = b.we; m1_size = b.size; m1_addr = b.addr; m1_wdata = b.wdata;
  endtask

  task automatic next_cycle();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctl"}, {56'h0, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err,
                        dm_ena, dm_wena}, 64'h0);
    chk({tag, "_rdata"}, {m0_rdata, m1_rdata}, 64'h0);
    chk({tag, "_dm"}, {dm_addr | dm_wdata, 30'h0, dm_size}, 64'h0);
  endtask

  vec_t vecs [NVEC];
  logic [1:0] exp_gnt;

  initial begin
    // Row k: inputs held during cycle k, outputs expected mid-cycle k.
    vecs[0]  = '{m0: rd(SW, 32'h1001_0004), m1: IDLE, gnt: 2'b01, r0: NR, r1: NR, dm: DOFF};
    vecs[1]  = '{m0: IDLE, m1: IDLE, gnt: 2'b00, r0: NR, r1: NR, dm: dmx(1'b0, SW, 32'h4, 32'h0)};
    vecs[2]  = '{m0: IDLE, m1: IDLE, gnt: 2'b00, r0: rsp(32'hDEAD_BEEF, 1'b0), r1: NR, dm: DOFF};
    vecs[3]  = '{m0: IDLE, m1: wr(SB, 32'h1001_0002, 32'hA5), gnt: 2'b10, r0: NR, r1: NR, dm: DOFF};
    vecs[4]  = '{m0: IDLE, m1: rd(SW, 32'h1001_0000), gnt: 2'b10, r0: NR, r1: NR,
                 dm: dmx(1'b1, SB, 32'h2, 32'hA5)};
    vecs[5]  = '{m0: IDLE, m1: IDLE, gnt: 2'b00, r0: NR, r1: rsp(32'h0, 1'b0),
                 dm: dmx(1'b0, SW, 32'h0, 32'h0)};
    vecs[6]  = '{m0: IDLE, m1: IDLE, gnt: 2'b00, r0: NR, r1: rsp(32'h11A5_3344, 1'b0), dm: DOFF};
    vecs[7]  = '{m0: rd(SH, 32'h1001_0001), m1: IDLE, gnt: 2'b01, r0: NR, r1: NR, dm: DOFF};
    vecs[8]  = '{m0: rd(SW, 32'h1001_0006), m1: IDLE, gnt: 2'b01, r0: NR, r1: NR, dm: DOFF};
    vecs[9]  = '{m0: IDLE, m1: IDLE, gnt: 2'b00, r0: rsp(32'h0, 1'b1), r1: NR, dm: DOFF};
    vecs[10] = '{m0: IDLE, m1: IDLE, gnt: 2'b00, r0: rsp(32'h0, 1'b1), r1: NR, dm: DOFF};
    vecs[11] = '{m0: rd(SW, 32'h1001_0000), m1: rd(SW, 32'h1001_0004), gnt: 2'b01,
                 r0: NR, r1: NR, dm: DOFF};
    vecs[12] = '{m0: IDLE, m1: rd(SW, 32'h1001_0004), gnt: 2'b10, r0: NR, r1: NR,
                 dm: dmx(1'b0, SW, 32'h0, 32'h0)};
    vecs[13] = '{m0: IDLE, m1: IDLE, gnt: 2'b00, r0: rsp(32'h11A5_3344, 1'b0), r1: NR,
                 dm: dmx(1'b0, SW, 32'h4, 32'h0)};
    vecs[14] = '{m0: IDLE, m1: IDLE, gnt: 2'b00, r0: NR, r1: rsp(32'hDEAD_BEEF, 1'b0), dm: DOFF};
    vecs[15] = '{m0: wr(SH, 32'h1001_0006, 32'h1234), m1: IDLE, gnt: 2'b01, r0: NR, r1: NR, dm: DOFF};
    vecs[16] = '{m0: rd(SB, 32'h1001_0007), m1: IDLE, gnt: 2'b01, r0: NR, r1: NR,
                 dm: dmx(1'b1, SH, 32'h6, 32'h1234)};
    vecs[17] = '{m0: IDLE, m1: IDLE, gnt: 2'b00, r0: rsp(32'h0, 1'b0), r1: NR,
                 dm: dmx(1'b0, SB, 32'h7, 32'h0)};
    vecs[18] = '{m0: IDLE, m1: IDLE, gnt: 2'b00, r0: rsp(32'h12, 1'b0), r1: NR, dm: DOFF};
    vecs[19] = '{m0: rd(2'b11, 32'h1001_0004), m1: IDLE, gnt: 2'b01, r0: NR, r1: NR, dm: DOFF};
    vecs[20] = '{m0: IDLE, m1: IDLE, gnt: 2'b00, r0: NR, r1: NR, dm: dmx(1'b0, SW, 32'h4, 32'h0)};
    vecs[21] = '{m0: IDLE, m1: IDLE, gnt: 2'b00, r0: rsp(32'h1234_BEEF, 1'b0), r1: NR, dm: DOFF};

    // reset phase: outputs must be zero while reset is low
    drive(IDLE, IDLE);
    repeat (2) begin
      @(negedge clk_in);
      chk_all_zero("reset");
    end
    reset = 1'b1;
    next_cycle();

    // table-driven section
    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].m0, vecs[i].m1);
      @(negedge clk_in);
      chk($sformatf("row%0d_gnt", i), {62'h0, m1_gnt, m0_gnt}, {62'h0, vecs[i].gnt});
      chk($sformatf("row%0d_rsp0", i), {30'h0, m0_rvalid, m0_err, m0_rdata}, {30'h0, vecs[i].r0});
      chk($sformatf("row%0d_rsp1", i), {30'h0, m1_rvalid, m1_err, m1_rdata}, {30'h0, vecs[i].r1});
      chk($sformatf("row%0d_dm_en", i), {62'h0, dm_ena, dm_wena},
          {62'h0, vecs[i].dm.ena, vecs[i].dm.wena});
      if (vecs[i].dm.ena) begin
        chk($sformatf("row%0d_dm_bus", i), {dm_addr, dm_wdata}, {vecs[i].dm.addr, vecs[i].dm.wdata});
        chk($sformatf("row%0d_dm_size", i), {62'h0, dm_size}, {62'h0, vecs[i].dm.size});
      end
      next_cycle();
    end

    // starvation: both masters request continuously, expect 4x M0 then 1x M1
    drive(rd(SW, 32'h1001_0000), rd(SW, 32'h1001_0004));
    for (int c = 0; c < 10; c++) begin
      exp_gnt = ((c % 5) == 4) ? 2'b10 : 2'b01;
      @(negedge clk_in);
      chk($sformatf("starve_c%0d_gnt", c), {62'h0, m1_gnt, m0_gnt}, {62'h0, exp_gnt});
      next_cycle();
    end
    drive(IDLE, IDLE);
    repeat (3) next_cycle();

    // reset during ACCESS: in-flight read dropped, outputs held at zero
    drive(rd(SW, 32'h1001_0004), IDLE);
    @(negedge clk_in);
    chk("rst_seq_gnt", {63'h0, m0_gnt}, 64'h1);
    next_cycle();
    reset = 1'b0;
    #1;
    repeat (2) begin
      @(negedge clk_in);
      chk_all_zero("mid_reset");
    end
    reset = 1'b1;
    drive(IDLE, IDLE);
    next_cycle();
    @(negedge clk_in);
    chk("post_rst_no_rvalid", {62'h0, m0_rvalid, m1_rvalid}, 64'h0);
    next_cycle();

    // a fresh read after release completes normally
    drive(rd(SW, 32'h1001_0004), IDLE);
    @(negedge clk_in);
    chk("post_rst_gnt", {62'h0, m1_gnt, m0_gnt}, 64'h1);
    next_cycle();
    drive(IDLE, IDLE);
    @(negedge clk_in);
    chk("post_rst_dm", {31'h0, dm_ena, dm_addr}, {31'h0, 1'b1, 32'h4});
    next_cycle();
    @(negedge clk_in);
    chk("post_rst_rsp", {30'h0, m0_rvalid, m0_err, m0_rdata}, {30'h0, 1'b1, 1'b0, 32'hDEAD_BEEF});
    next_cycle();

    // final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // guard against a stalled run
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", n_checks, n_errors);
    $fatal(1);
  end

endmodule
